// File: rtl/legv8_pkg.sv
// Shared LegV8 front-end definitions: next-PC select codes, fetch-unit state encoding
// and the instruction word width.
package legv8_pkg;

  localparam int INSTR_WIDTH = 32;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_REG    = 2'b10;
  localparam logic [1:0] PC_SEL_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IFU_FETCH = 2'b00,
    IFU_HOLD  = 2'b01,
    IFU_FAULT = 2'b10
  } ifu_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch or register target.
// With IFU_ALIGN_CHECK_EN the raw target and a misaligned flag are produced; otherwise the
// target is forced to a word boundary.
module next_pc_calc
  import legv8_pkg::*;
#(
  parameter int PC_WIDTH = 64
) (
  input  logic                       [PC_WIDTH-1:0] pc,
  input  logic                       [1:0]          pc_sel,
  input  logic signed                [PC_WIDTH-1:0] branch_offset,
  input  logic                       [PC_WIDTH-1:0] reg_target,
`ifdef IFU_ALIGN_CHECK_EN
  output logic                                      misaligned,
`endif
  output logic                       [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] off_bytes;
  logic [PC_WIDTH-1:0] raw_pc;

  // Branch offset is in words and taken from the branch's own PC; sums wrap silently.
  assign off_bytes = $unsigned(branch_offset) << 2;

  always_comb begin
    raw_pc = pc + PC_WIDTH'(4);
    case (pc_sel)
      PC_SEL_BRANCH: raw_pc = pc + off_bytes;
      PC_SEL_REG:    raw_pc = reg_target;
      default:       raw_pc = pc + PC_WIDTH'(4);
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign misaligned = |raw_pc[1:0];
  assign next_pc    = raw_pc;
`else
  assign next_pc    = raw_pc & ~PC_WIDTH'(3);
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// LegV8 instruction fetch unit: owns the PC, fetches over a req/valid handshake and holds
// the word for controlUnit until advance. IFU_ALIGN_CHECK_EN enables the sticky fault state.
module instruction_fetch_unit
  import legv8_pkg::*;
#(
  parameter int                 PC_WIDTH    = 64,
  parameter int                 INSTR_WIDTH = legv8_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       advance,
  input  logic        [1:0]          pc_sel,
  input  logic signed [PC_WIDTH-1:0] branch_offset,
  input  logic        [PC_WIDTH-1:0] reg_target,
  output logic                       imem_req,
  output logic        [PC_WIDTH-1:0] imem_addr,
  input  logic     [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                       imem_valid,
  output logic     [INSTR_WIDTH-1:0] instruction,
  output logic                       instr_valid,
  output logic        [PC_WIDTH-1:0] pc,
  output logic                       fault
);

  ifu_state_e          state;
  logic [PC_WIDTH-1:0] next_pc;
`ifdef IFU_ALIGN_CHECK_EN
  logic                misaligned;
`endif

  next_pc_calc #(
    .PC_WIDTH(PC_WIDTH)
  ) u_next_pc_calc (
    .pc           (pc),
    .pc_sel       (pc_sel),
    .branch_offset(branch_offset),
    .reg_target   (reg_target),
`ifdef IFU_ALIGN_CHECK_EN
    .misaligned   (misaligned),
`endif
    .next_pc      (next_pc)
  );

  assign imem_addr = pc;

  // imem_req is registered and mirrors state==IFU_FETCH, so a response is only
  // ever consumed while a request is outstanding.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IFU_FETCH;
      pc          <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b1;
`ifdef IFU_ALIGN_CHECK_EN
      fault       <= 1'b0;
`endif
    end else begin
      case (state)
        IFU_FETCH: begin
          if (imem_valid) begin
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= IFU_HOLD;
          end
        end
        IFU_HOLD: begin
          if (advance) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            if (misaligned) begin
              fault    <= 1'b1;
              imem_req <= 1'b0;
              state    <= IFU_FAULT;
            end else begin
              imem_req <= 1'b1;
              state    <= IFU_FETCH;
            end
`else
            imem_req    <= 1'b1;
            state       <= IFU_FETCH;
`endif
          end
        end
`ifdef IFU_ALIGN_CHECK_EN
        IFU_FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
`endif
        default: begin
          imem_req <= 1'b1;
          state    <= IFU_FETCH;
        end
      endcase
    end
  end

`ifndef IFU_ALIGN_CHECK_EN
  assign fault = 1'b0;
`endif

endmodule
